// File: rtl/lcd_8080_pkg.sv
// ============================================================================
// Module : lcd_8080_pkg
// Brief  : Shared command codes, decode states and pixel entry layout for
//          the 8080-bus receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_8080_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  localparam int PIX_COORD_W = 9;
  localparam int PIX_DATA_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAS  = 2'd1,
    ST_PAS  = 2'd2,
    ST_RAM  = 2'd3
  } state_e;

  // Entry layout in the default configuration; the FIFO stores it packed.
  typedef struct packed {
    logic [PIX_COORD_W-1:0] x;
    logic [PIX_COORD_W-1:0] y;
    logic [PIX_DATA_W-1:0]  data;
  } pix_entry_t;

endpackage

`default_nettype wire

// File: rtl/lcd_rx_fifo.sv
// ============================================================================
// Module : lcd_rx_fifo
// Brief  : First-word fall-through FIFO; a push into a full FIFO is taken
//          only when a pop happens in the same cycle, otherwise it is dropped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_rx_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;

  logic w_empty, w_full, w_pop, w_wr;

  assign w_empty = (cnt_q == '0);
  assign w_full  = (cnt_q == (AW+1)'(DEPTH));
  assign w_pop   = pop_i & ~w_empty;
  assign w_wr    = push_i & (~w_full | w_pop);
  assign drop_o  = push_i & w_full & ~w_pop;
  assign valid_o = ~w_empty;
  assign data_o  = w_empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_wr)  wr_q <= wr_q + 1'b1;
      if (w_pop) rd_q <= rd_q + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_8080_rx.sv
// ============================================================================
// Module : lcd_8080_rx
// Brief  : 8080 parallel write-bus receiver with CASET/PASET/RAMWR decode and
//          an addressed pixel stream. Macro LCD_RX_RAMWRC_EN adds 0x3C.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_8080_rx
  import lcd_8080_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int COORD_W     = 9,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lcd_cs_n,
  input  logic               lcd_d_c_n,
  input  logic               lcd_wr_n,
  input  logic [DATA_W-1:0]  lcd_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [DATA_W-1:0]  pix_data,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic               frame_start
);

  localparam int BW  = DATA_W + 3;
  localparam int EW  = 2*COORD_W + DATA_W;
  localparam logic [BW-1:0] C_BUS_IDLE = {3'b111, {DATA_W{1'b0}}};

  logic [SYNC_STAGES-1:0][BW-1:0] sync_q;
  logic [BW-1:0]       prev_q;
  logic                evt_q, evt_dc_q;
  logic [DATA_W-1:0]   evt_data_q;
  logic                w_evt;

  // Bus bits are sampled in lock-step; cs/wr idle high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{C_BUS_IDLE}};
      prev_q     <= C_BUS_IDLE;
      evt_q      <= 1'b0;
      evt_dc_q   <= 1'b0;
      evt_data_q <= '0;
    end else begin
      sync_q[0] <= {lcd_cs_n, lcd_d_c_n, lcd_wr_n, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q     <= sync_q[SYNC_STAGES-1];
      evt_q      <= w_evt;
      evt_dc_q   <= prev_q[BW-2];
      evt_data_q <= prev_q[DATA_W-1:0];
    end
  end

  assign w_evt = sync_q[SYNC_STAGES-1][BW-3] & ~prev_q[BW-3] & ~prev_q[BW-1];

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [COORD_W-1:0] ws_q, ws_d, we_q, we_d;
  logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic               fs_q, fs_d, ovf_q;
  logic               w_push, w_drop;
  logic [7:0]         w_b;

  assign w_b = evt_data_q[7:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ws_d    = ws_q;
    we_d    = we_q;
    sc_d    = sc_q;
    ec_d    = ec_q;
    sp_d    = sp_q;
    ep_d    = ep_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fs_d    = 1'b0;
    w_push  = 1'b0;
    if (evt_q) begin
      if (!evt_dc_q) begin
        idx_d = 2'd0;
        case (w_b)
          CMD_CASET: state_d = ST_CAS;
          CMD_PASET: state_d = ST_PAS;
          CMD_RAMWR: begin
            state_d = ST_RAM;
            cx_d    = sc_q;
            cy_d    = sp_q;
            fs_d    = 1'b1;
          end
`ifdef LCD_RX_RAMWRC_EN
          CMD_RAMWRC: state_d = ST_RAM;
`endif
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_CAS, ST_PAS: begin
            idx_d = idx_q + 2'd1;
            // High byte lands first, so the low byte can simply be OR-ed in.
            case (idx_q)
              2'd0: ws_d = COORD_W'({w_b, 8'h00});
              2'd1: ws_d = ws_q | COORD_W'(w_b);
              2'd2: we_d = COORD_W'({w_b, 8'h00});
              default: begin
                state_d = ST_IDLE;
                if (state_q == ST_CAS) begin
                  sc_d = ws_q;
                  ec_d = we_q | COORD_W'(w_b);
                end else begin
                  sp_d = ws_q;
                  ep_d = we_q | COORD_W'(w_b);
                end
              end
            endcase
          end
          ST_RAM: begin
            w_push = 1'b1;
            if (cx_q == ec_q) begin
              cx_d = sc_q;
              cy_d = (cy_q == ep_q) ? sp_q : cy_q + COORD_W'(1);
            end else begin
              cx_d = cx_q + COORD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      ws_q    <= '0;
      we_q    <= '0;
      sc_q    <= '0;
      ec_q    <= '1;
      sp_q    <= '0;
      ep_q    <= '1;
      cx_q    <= '0;
      cy_q    <= '0;
      fs_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ws_q    <= ws_d;
      we_q    <= we_d;
      sc_q    <= sc_d;
      ec_q    <= ec_d;
      sp_q    <= sp_d;
      ep_q    <= ep_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fs_q    <= fs_d;
      if (w_drop)       ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  logic [EW-1:0] w_head;

  lcd_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  ({cx_q, cy_q, evt_data_q}),
    .pop_i   (pix_valid & pix_ready),
    .valid_o (pix_valid),
    .data_o  (w_head),
    .drop_o  (w_drop)
  );

  assign pix_x       = w_head[EW-1 -: COORD_W];
  assign pix_y       = w_head[DATA_W +: COORD_W];
  assign pix_data    = w_head[DATA_W-1:0];
  assign ovf         = ovf_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_8080_rx.sv
// ============================================================================
// Module : tb_lcd_8080_rx
// Brief  : Directed, table-driven bench for lcd_8080_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_8080_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1, dc_n = 1'b1, wr_n = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        pix_ready = 1'b1, ovf_clr = 1'b0;
  logic        pix_valid, ovf, frame_start;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  always #5 clk = ~clk;

  lcd_8080_rx #(
    .DATA_W(16), .COORD_W(9), .SYNC_STAGES(2), .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_cs_n    (cs_n),
    .lcd_d_c_n   (dc_n),
    .lcd_wr_n    (wr_n),
    .lcd_data    (data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  localparam int OP_CMD = 0, OP_DAT = 1, OP_CSH = 2, OP_RST = 3;

  typedef struct {
    int          op;
    logic [15:0] d;
    bit          exp_push;
    int          ex;
    int          ey;
    int          fs;
  } vec_t;

  pix_t got_q[$];
  vec_t tbl[$];
  int   fs_cnt = 0;
  int   checks = 0, failures = 0;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y, pix_data});
    if (frame_start) fs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic cs, input logic dc, input logic [15:0] d);
    tick;
    cs_n = cs; dc_n = dc; data = d; wr_n = 1'b0;
    repeat (4) tick;
    wr_n = 1'b1;
    repeat (4) tick;
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    got_q.delete();
  endtask

  function automatic void add(int op, logic [15:0] d, bit ep, int ex, int ey, int fs);
    vec_t v;
    v.op = op; v.d = d; v.exp_push = ep; v.ex = ex; v.ey = ey; v.fs = fs;
    tbl.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Window 2..3 x 5..6, five pixels wrap back to the start corner.
    add(OP_CMD, 16'h002A, 0, 0, 0, 0);
    add(OP_DAT, 16'hAB00, 0, 0, 0, 0);
    add(OP_DAT, 16'h0002, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'hCD03, 0, 0, 0, 0);
    add(OP_CMD, 16'h002B, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0005, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0006, 0, 0, 0, 0);
    add(OP_CMD, 16'h002C, 0, 0, 0, 1);
    add(OP_DAT, 16'hAAAA, 1, 2, 5, 0);
    add(OP_DAT, 16'hBBBB, 1, 3, 5, 0);
    add(OP_DAT, 16'hCCCC, 1, 2, 6, 0);
    add(OP_DAT, 16'hDDDD, 1, 3, 6, 0);
    add(OP_DAT, 16'hEEEE, 1, 2, 5, 0);
    // Aborted CASET keeps the reset window.
    add(OP_RST, 16'h0000, 0, 0, 0, 0);
    add(OP_CMD, 16'h002A, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0007, 0, 0, 0, 0);
    add(OP_CMD, 16'h002C, 0, 0, 0, 1);
    add(OP_DAT, 16'h1111, 1, 0, 0, 0);
    add(OP_DAT, 16'h2222, 1, 1, 0, 0);
    add(OP_DAT, 16'h3333, 1, 2, 0, 0);
    // Deselected RAMWR is ignored, so data in IDLE emits nothing.
    add(OP_CMD, 16'h0000, 0, 0, 0, 0);
    add(OP_CSH, 16'h002C, 0, 0, 0, 0);
    add(OP_DAT, 16'h1234, 0, 0, 0, 0);
    // Memory-write-continue.
    add(OP_RST, 16'h0000, 0, 0, 0, 0);
    add(OP_CMD, 16'h002A, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0001, 0, 0, 0, 0);
    add(OP_CMD, 16'h002B, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0000, 0, 0, 0, 0);
    add(OP_DAT, 16'h0001, 0, 0, 0, 0);
    add(OP_CMD, 16'h002C, 0, 0, 0, 1);
    add(OP_DAT, 16'h4001, 1, 0, 0, 0);
    add(OP_DAT, 16'h4002, 1, 1, 0, 0);
    add(OP_DAT, 16'h4003, 1, 0, 1, 0);
    add(OP_CMD, 16'h0000, 0, 0, 0, 0);
    add(OP_CMD, 16'h003C, 0, 0, 0, 0);
`ifdef LCD_RX_RAMWRC_EN
    add(OP_DAT, 16'h4004, 1, 1, 1, 0);
`else
    add(OP_DAT, 16'h4004, 0, 0, 0, 0);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst pix_valid", pix_valid, 0);
    chk("rst pix_x", pix_x, 0);
    chk("rst pix_y", pix_y, 0);
    chk("rst pix_data", pix_data, 0);
    chk("rst ovf", ovf, 0);
    chk("rst frame_start", frame_start, 0);
    tick;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      int fs0;
      fs0 = fs_cnt;
      case (tbl[i].op)
        OP_RST:  do_reset;
        OP_CMD:  bus_write(1'b0, 1'b0, tbl[i].d);
        OP_DAT:  bus_write(1'b0, 1'b1, tbl[i].d);
        default: bus_write(1'b1, 1'b0, tbl[i].d);
      endcase
      repeat (3) @(negedge clk);
      if (tbl[i].exp_push) begin
        chk($sformatf("row%0d count", i), got_q.size(), 1);
        if (got_q.size() > 0) begin
          pix_t p;
          p = got_q.pop_front();
          chk($sformatf("row%0d x", i), p.x, tbl[i].ex);
          chk($sformatf("row%0d y", i), p.y, tbl[i].ey);
          chk($sformatf("row%0d data", i), p.d, tbl[i].d);
        end
      end else begin
        chk($sformatf("row%0d count", i), got_q.size(), 0);
      end
      chk($sformatf("row%0d frame_start", i), fs_cnt - fs0, tbl[i].fs);
      got_q.delete();
    end

    // Overflow: 10 pixels into 8 entries, drops still advance the cursor.
    do_reset;
    pix_ready = 1'b0;
    bus_write(1'b0, 1'b0, 16'h002C);
    for (int k = 0; k < 10; k++) bus_write(1'b0, 1'b1, 16'(k));
    repeat (3) @(negedge clk);
    chk("ovf set", ovf, 1);
    chk("ovf held valid", pix_valid, 1);
    tick;
    pix_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("ovf drain count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (got_q.size() > 0) begin
        pix_t p;
        p = got_q.pop_front();
        chk($sformatf("ovf drain%0d data", k), p.d, k);
        chk($sformatf("ovf drain%0d x", k), p.x, k);
      end
    end
    chk("ovf sticky", ovf, 1);
    tick;
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf cleared", ovf, 0);
    bus_write(1'b0, 1'b1, 16'h0055);
    repeat (3) @(negedge clk);
    chk("post ovf count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      pix_t p;
      p = got_q.pop_front();
      chk("post ovf x", p.x, 10);
      chk("post ovf y", p.y, 0);
    end

    // Reset mid-RAMWR with three entries queued.
    do_reset;
    bus_write(1'b0, 1'b0, 16'h002C);
    tick;
    pix_ready = 1'b0;
    for (int k = 0; k < 3; k++) bus_write(1'b0, 1'b1, 16'h0100 + 16'(k));
    repeat (3) @(negedge clk);
    chk("midrst held valid", pix_valid, 1);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst valid cleared", pix_valid, 0);
    tick;
    reset = 1'b0;
    pix_ready = 1'b1;
    got_q.delete();
    bus_write(1'b0, 1'b1, 16'h0777);
    repeat (3) @(negedge clk);
    chk("midrst no pixel", got_q.size(), 0);

    // Pre-edge capture and pin-to-valid latency.
    do_reset;
    bus_write(1'b0, 1'b0, 16'h002C);
    tick;
    cs_n = 1'b0; dc_n = 1'b1; data = 16'hBEEF; wr_n = 1'b0;
    repeat (5) tick;
    wr_n = 1'b1;
    tick;
    data = 16'h0BAD;
    repeat (3) @(negedge clk);
    chk("latency early", pix_valid, 0);
    @(negedge clk);
    chk("latency valid", pix_valid, 1);
    chk("pre-edge data", pix_data, 16'hBEEF);
    chk("pre-edge x", pix_x, 0);
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
